vx_mem_responder: RTL and testbench
===================================

# VX_mem_responder

Memory-side responder for the Vortex request/response memory protocol. It accepts requests (valid/rw/byteen/addr/data/tag/ready), performs byte-masked writes and fixed-latency reads on an internal word array, and returns read data with the original tag on a valid/data/tag/ready response channel. It serves as the backing store behind cache or scratchpad request ports in simulation and small on-chip configurations. A credit counter guarantees that every accepted read has a response slot, so responses are never dropped.

## Interface
- DATA_WIDTH, 512: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8: word address width; array depth is 2^ADDR_WIDTH.
- TAG_WIDTH, 8: request/response tag width.
- LATENCY, 2: read pipeline depth in cycles, 1..8.
- RSP_QUEUE_SIZE, 4: response FIFO depth and credit limit; power of 2, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_rw  in  1  1 = write, 0 = read.
- req_byteen  in  DATA_WIDTH/8  write byte enables; ignored on reads.
- req_addr  in  ADDR_WIDTH  word address.
- req_data  in  DATA_WIDTH  write data.
- req_tag  in  TAG_WIDTH  request tag.
- req_ready  out  1  request accepted when req_valid && req_ready.
- rsp_valid  out  1  response valid.
- rsp_data  out  DATA_WIDTH  read data.
- rsp_tag  out  TAG_WIDTH  tag of the originating read.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.

## Operation
- req_fire = req_valid && req_ready. rsp_fire = rsp_valid && rsp_ready.
- Write (req_rw = 1): on req_fire, each byte i with req_byteen[i] = 1 is updated. Writes produce no response and consume no credit.
- Read (req_rw = 0): on req_fire, the array word is read and {data, tag} enters a LATENCY-stage valid-tagged shift pipeline. At the pipeline exit it is pushed into the response FIFO.
- Credit counter `pending` (0..RSP_QUEUE_SIZE, width clog2(RSP_QUEUE_SIZE+1)):
  - increments on a read req_fire;
  - decrements on rsp_fire;
  - stays unchanged when both happen in the same cycle.
- req_ready = !reset && (pending != RSP_QUEUE_SIZE). This applies to reads and writes alike, with no same-cycle bypass from rsp_fire.
- The pipeline never stalls. The credit rule guarantees that a FIFO push never meets a full FIFO. An overflow is an assertion failure.
- Responses return in request order.
- A write at cycle t is visible to a read accepted at cycle t+1 or later. Requests are serialized one per cycle, so there is no same-cycle hazard.
- rsp_valid = FIFO not empty. rsp_data and rsp_tag are the FIFO head and are held stable while rsp_valid && !rsp_ready.

## Timing
- Reset values: rsp_valid = 0, req_ready = 0 while reset is high, pending = 0, pipeline valids = 0, FIFO empty. rsp_data and rsp_tag are don't-care while rsp_valid = 0.
- Array contents are not reset.
- First cycle after reset deasserts: req_ready = 1.
- Read latency: a read req_fire at cycle t gives rsp_valid at cycle t+LATENCY when the FIFO is empty (first-word visible on the cycle of push+1 is not allowed; push and visibility are counted within LATENCY).
- Throughput: one read per cycle sustained while rsp_ready = 1 and RSP_QUEUE_SIZE ≥ LATENCY+1. Below that depth, read throughput is credit-limited.
- Full boundary: when pending = RSP_QUEUE_SIZE, req_ready = 0 in that same cycle. It returns to 1 in the cycle after the rsp_fire.
- Reset mid-operation: in-flight reads and queued responses are discarded, with no response emitted. Array contents are retained.

## Structure
- Shared package holds:
  - the response entry typedef {data, tag};
  - the LATENCY bounds constants;
  - the credit-width function, clog2(RSP_QUEUE_SIZE+1).
- One sub-module, VX_mem_rsp_fifo: synchronous FIFO with push/pop/full/empty, depth RSP_QUEUE_SIZE, and registered head.
- The array, byte-mask write, read pipeline and credit counter live in the top module.

## Test plan
- Write 0xA5 to all bytes at addr 5 (full byteen), then read addr 5 with tag 3 → with LATENCY = 2, rsp_valid rises 2 cycles after the read fire, rsp_data = all 0xA5, rsp_tag = 3.
- Write all-0x00 to addr 7, then write 0xFF with byteen = 0x…0F, then read → only the low 4 bytes are 0xFF, the rest 0x00.
- Hold rsp_ready = 0 and issue 6 reads, tags 0..5 → req_ready drops after the 4th fire and pending = 4. Raise rsp_ready → tags 0..5 return in order, none lost or duplicated.
- At pending = 4, a rsp_fire occurs with req_valid read high → no accept that cycle. The next cycle accepts, and pending goes 4→3→4.
- Read at cycle t immediately after a write to the same address at t−1 → the response returns the new data.
- Assert reset with 2 reads in the pipeline and 1 response queued → rsp_valid = 0 and req_ready = 0 during reset. No stale responses appear afterward, and a subsequent read returns the data written before reset.

Source files
------------

// File: rtl/vx_mem_responder_pkg.sv
// rtl/vx_mem_responder_pkg.sv - shared types and constants for the memory responder
package vx_mem_responder_pkg;

    localparam int VX_DATA_WIDTH = 512;
    localparam int VX_TAG_WIDTH  = 8;
    localparam int LATENCY_MIN   = 1;
    localparam int LATENCY_MAX   = 8;

    typedef struct packed {
        logic [VX_DATA_WIDTH-1:0] data;
        logic [VX_TAG_WIDTH-1:0]  tag;
    } rsp_entry_t;

    // Credit counter must reach queue_size inclusive.
    function automatic int credit_width(input int queue_size);
        return $clog2(queue_size + 1);
    endfunction

endpackage

// File: rtl/vx_mem_responder_rsp_fifo.sv
// rtl/vx_mem_responder_rsp_fifo.sv - response FIFO with registered head entry
module vx_mem_rsp_fifo #(
    parameter int WIDTH = 520,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // The head lives in its own register; body holds the entries behind it.
    logic [WIDTH-1:0] body [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             pop_ok;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign pop_ok = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count == '0) begin
                        head <= push_data;
                    end else begin
                        body[wr_ptr] <= push_data;
                        wr_ptr       <= wr_ptr + 1'b1;
                    end
                    count <= count + 1'b1;
                end
                2'b01: begin
                    if (count > CW'(1)) begin
                        head   <= body[rd_ptr];
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    count <= count - 1'b1;
                end
                2'b11: begin
                    if (count == CW'(1)) begin
                        head <= push_data;
                    end else begin
                        head         <= body[rd_ptr];
                        rd_ptr       <= rd_ptr + 1'b1;
                        body[wr_ptr] <= push_data;
                        wr_ptr       <= wr_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vx_mem_responder.sv
// rtl/vx_mem_responder.sv - byte-masked word store with fixed-latency tagged read responses
module vx_mem_responder
    import vx_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH     = VX_DATA_WIDTH,
    parameter int ADDR_WIDTH     = 8,
    parameter int TAG_WIDTH      = VX_TAG_WIDTH,
    parameter int LATENCY        = 2,
    parameter int RSP_QUEUE_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_rw,
    input  logic [DATA_WIDTH/8-1:0] req_byteen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_data,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    output logic                    req_ready,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [TAG_WIDTH-1:0]    rsp_tag,
    input  logic                    rsp_ready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int WORDS = 1 << ADDR_WIDTH;
    localparam int CW    = credit_width(RSP_QUEUE_SIZE);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic [CW-1:0]         pending;
    logic                  req_fire;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  rsp_fire;
    entry_t                in_entry;
    entry_t                push_entry;
    logic                  push_valid;
    entry_t                head;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign req_ready = !reset && (pending != CW'(RSP_QUEUE_SIZE));
    assign req_fire  = req_valid && req_ready;
    assign rd_fire   = req_fire && !req_rw;
    assign wr_fire   = req_fire && req_rw;
    assign rsp_fire  = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < BYTES; i++) begin
                if (req_byteen[i]) begin
                    mem[req_addr][i*8 +: 8] <= req_data[i*8 +: 8];
                end
            end
        end
    end

    assign in_entry.data = mem[req_addr];
    assign in_entry.tag  = req_tag;

    // The FIFO push edge is the last of the LATENCY stages, so only LATENCY-1 registers precede it.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push_valid = rd_fire;
            assign push_entry = in_entry;
        end else begin : g_pipe
            logic [LATENCY-2:0] stage_valid;
            entry_t             stage_entry [LATENCY-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_valid <= '0;
                end else begin
                    stage_valid[0] <= rd_fire;
                    for (int k = 1; k < LATENCY - 1; k++) begin
                        stage_valid[k] <= stage_valid[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                stage_entry[0] <= in_entry;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    stage_entry[k] <= stage_entry[k-1];
                end
            end

            assign push_valid = stage_valid[LATENCY-2];
            assign push_entry = stage_entry[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            case ({rd_fire, rsp_fire})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    vx_mem_rsp_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (RSP_QUEUE_SIZE)
    ) rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_valid),
        .push_data (push_entry),
        .pop       (rsp_fire),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = head.data;
    assign rsp_tag   = head.tag;

    // Credits bound pipeline plus FIFO occupancy, so a push can never see a full FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (LATENCY >= LATENCY_MIN && LATENCY <= LATENCY_MAX);
            assert (!(push_valid && fifo_full));
            assert (pending <= CW'(RSP_QUEUE_SIZE));
        end
    end

endmodule

// File: tb/tb_vx_mem_responder.sv
// tb/tb_vx_mem_responder.sv - directed self-checking bench for vx_mem_responder
module tb_vx_mem_responder;
    import vx_mem_responder_pkg::*;

    localparam int DW = 512;
    localparam int AW = 8;
    localparam int TW = 8;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_rw;
    logic [BW-1:0] req_byteen;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [TW-1:0] req_tag;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_ready;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vx_mem_responder #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TAG_WIDTH      (TW),
        .LATENCY        (2),
        .RSP_QUEUE_SIZE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_byteen (req_byteen),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] word_of(input int i);
        return {16{32'hC0DE0000 + 32'(i)}};
    endfunction

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        check("wr_ready", req_ready, 1);
        req_valid = 1; req_rw = 1; req_addr = a; req_data = d; req_byteen = be;
        tick();
        req_valid = 0; req_rw = 0;
    endtask

    task automatic read_word(input logic [AW-1:0] a, input logic [TW-1:0] t);
        check("rd_ready", req_ready, 1);
        req_valid = 1; req_rw = 0; req_addr = a; req_tag = t;
        tick();
        req_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int         got;
        logic       fired;
        rsp_entry_t seen;

        reset = 1; req_valid = 0; req_rw = 0; req_byteen = '0; req_addr = '0;
        req_data = '0; req_tag = '0; rsp_ready = 0;
        repeat (3) tick();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_pending", dut.pending, 0);
        reset = 0;
        #1;
        check("ready_after_reset", req_ready, 1);

        // full-word write then read, latency 2
        write_word(8'd5, {64{8'hA5}}, '1);
        read_word(8'd5, 8'd3);
        check("lat_early", rsp_valid, 0);
        tick();
        check("lat_valid", rsp_valid, 1);
        check("a5_data", rsp_data, {64{8'hA5}});
        check("a5_tag", rsp_tag, 3);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("a5_drained", rsp_valid, 0);
        check("a5_pending", dut.pending, 0);

        // partial byte enables
        write_word(8'd7, '0, '1);
        write_word(8'd7, '1, 64'hF);
        read_word(8'd7, 8'd9);
        tick();
        check("mask_valid", rsp_valid, 1);
        check("mask_data", rsp_data, 512'hFFFF_FFFF);
        check("mask_tag", rsp_tag, 9);
        rsp_ready = 1; tick(); rsp_ready = 0;

        // read right after overwrite
        write_word(8'd5, {16{32'h1234_5678}}, '1);
        read_word(8'd5, 8'h44);
        tick();
        check("raw_data", rsp_data, {16{32'h1234_5678}});
        check("raw_tag", rsp_tag, 8'h44);
        rsp_ready = 1; tick(); rsp_ready = 0;

        // credit fill with rsp_ready low
        for (int i = 0; i < 6; i++) write_word(AW'(10 + i), word_of(i), '1);
        req_valid = 1; req_rw = 0;
        for (int i = 0; i < 4; i++) begin
            req_addr = AW'(10 + i); req_tag = TW'(i);
            check("fill_ready", req_ready, 1);
            tick();
        end
        req_addr = 8'd14; req_tag = 8'd4;
        check("fill_blocked", req_ready, 0);
        check("fill_pending", dut.pending, 4);
        tick(); tick();
        check("still_blocked", req_ready, 0);
        check("full_pending", dut.pending, 4);
        check("full_rsp_valid", rsp_valid, 1);
        check("head_tag0", rsp_tag, 0);

        // pop at full: no same-cycle accept, 4 -> 3 -> 4
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("credit_dec", dut.pending, 3);
        check("ready_reopen", req_ready, 1);
        tick();
        check("credit_reinc", dut.pending, 4);
        check("reblocked", req_ready, 0);
        req_addr = 8'd15; req_tag = 8'd5;
        rsp_ready = 1;

        got = 1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (rsp_valid) begin
                seen = '{data: rsp_data, tag: rsp_tag};
                check("order_tag", seen.tag, got);
                check("order_data", seen.data, word_of(got));
                got++;
            end
            fired = req_valid && req_ready;
            tick();
            if (fired) req_valid = 0;
        end
        check("order_count", got, 6);
        tick(); tick();
        check("no_dup", rsp_valid, 0);
        check("drain_pending", dut.pending, 0);
        check("drain_ready", req_ready, 1);

        // reset with reads in flight and a response queued
        rsp_ready = 0;
        req_valid = 1; req_rw = 0;
        req_addr = 8'd10; req_tag = 8'd20; tick();
        req_addr = 8'd11; req_tag = 8'd21; tick();
        req_addr = 8'd12; req_tag = 8'd22; tick();
        req_valid = 0;
        check("pre_reset_valid", rsp_valid, 1);
        reset = 1;
        #1;
        check("mid_rst_ready", req_ready, 0);
        tick();
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_pending", dut.pending, 0);
        tick();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            check("no_stale", rsp_valid, 0);
            tick();
        end
        read_word(8'd7, 8'd30);
        tick();
        check("post_rst_valid", rsp_valid, 1);
        check("post_rst_data", rsp_data, 512'hFFFF_FFFF);
        check("post_rst_tag", rsp_tag, 30);
        rsp_ready = 1; tick(); rsp_ready = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
